// File: rtl/control_ack_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : control_ack_collector_pkg
// Purpose  : Shared control-path definitions for the control fan-out and the
//            ack collector: module count, module indices, config FSM state
//            type and the default acknowledge timeout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package control_ack_collector_pkg;

  localparam int N_MODULES              = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Bit positions of each acquisition module in ack / stopped vectors
  localparam int MOD0_IDX = 0;
  localparam int MOD1_IDX = 1;
  localparam int MOD2_IDX = 2;
  localparam int MOD3_IDX = 3;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } cfg_state_e;

  // True once every module has acknowledged
  function automatic logic all_acked(input logic [N_MODULES-1:0] mask);
    return &mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_ack_collector_timer.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_timeout_timer
// Purpose  : Load / decrement / zero-flag down-counter for handshake timeouts.
//            A load sets the count to TIMEOUT_CYCLES-1; decrement saturates
//            at zero so the counter never wraps.
// Ports    : clk_i   - clock
//            rst_i   - synchronous active-high reset (count cleared)
//            load_i  - reload with TIMEOUT_CYCLES-1 (wins over dec_i)
//            dec_i   - decrement while nonzero
//            zero_o  - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam logic [TIMER_WIDTH-1:0] LOAD_VALUE = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] count_q;
  logic [TIMER_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VALUE;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/control_ack_collector.sv
`default_nettype none
// ============================================================================
// Module   : control_ack_collector
// Purpose  : Collects per-module config acknowledges after a SET_CONFIG
//            broadcast and reduces them to a single DONE or TIMEOUT report
//            (with a mask of missing modules). Independently tracks STOP
//            requests until every module reports stopped.
// Ports    : CLK, RESET (sync, active-high)
//            SET_CONFIG, STOP          - 1-cycle request pulses
//            CONFIG_ACK_MOD0..3        - 1-cycle ack pulses per module
//            STOPPED_MOD0..3           - per-module stopped levels
//            BUSY                      - waiting for acks
//            CONFIG_DONE/CONFIG_TIMEOUT- 1-cycle completion pulses
//            MISSING_ACK_MASK[3:0]     - modules missing at last timeout
//            STOP_DONE                 - 1-cycle pulse, all stopped after STOP
//            ALL_STOPPED               - registered AND of STOPPED_MOD0..3
// Revision : 1.0 - initial release
// ============================================================================
module control_ack_collector
  import control_ack_collector_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SET_CONFIG,
  input  logic       STOP,
  input  logic       CONFIG_ACK_MOD0,
  input  logic       CONFIG_ACK_MOD1,
  input  logic       CONFIG_ACK_MOD2,
  input  logic       CONFIG_ACK_MOD3,
  input  logic       STOPPED_MOD0,
  input  logic       STOPPED_MOD1,
  input  logic       STOPPED_MOD2,
  input  logic       STOPPED_MOD3,
  output logic       BUSY,
  output logic       CONFIG_DONE,
  output logic       CONFIG_TIMEOUT,
  output logic [3:0] MISSING_ACK_MASK,
  output logic       STOP_DONE,
  output logic       ALL_STOPPED
);

  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

  logic [N_MODULES-1:0] w_ack_vec;
  logic [N_MODULES-1:0] w_stopped_vec;
  logic [N_MODULES-1:0] w_next_mask;
  logic                 w_timer_load;
  logic                 w_timer_dec;
  logic                 w_timer_zero;
  logic                 w_stop_pending_d;

  cfg_state_e           state_q;
  logic [N_MODULES-1:0] mask_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 timeout_q;
  logic [N_MODULES-1:0] missing_q;
  logic                 all_stopped_q;
  logic                 stop_pending_q;
  logic                 stop_done_q;

  always_comb begin
    w_ack_vec               = '0;
    w_ack_vec[MOD0_IDX]     = CONFIG_ACK_MOD0;
    w_ack_vec[MOD1_IDX]     = CONFIG_ACK_MOD1;
    w_ack_vec[MOD2_IDX]     = CONFIG_ACK_MOD2;
    w_ack_vec[MOD3_IDX]     = CONFIG_ACK_MOD3;
    w_stopped_vec           = '0;
    w_stopped_vec[MOD0_IDX] = STOPPED_MOD0;
    w_stopped_vec[MOD1_IDX] = STOPPED_MOD1;
    w_stopped_vec[MOD2_IDX] = STOPPED_MOD2;
    w_stopped_vec[MOD3_IDX] = STOPPED_MOD3;
  end

  assign w_next_mask = mask_q | w_ack_vec;

  // Timer reloads on any accepted SET_CONFIG (a STOP in WAIT_ACK overrides
  // it). Decrementing every WAIT_ACK cycle is safe: the timer saturates at
  // zero and its value is irrelevant once the FSM returns to IDLE.
  assign w_timer_load = SET_CONFIG && ((state_q == ST_IDLE) || !STOP);
  assign w_timer_dec  = (state_q == ST_WAIT_ACK);

  ctrl_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMER_WIDTH    (TIMER_WIDTH)
  ) u_timer (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .load_i (w_timer_load),
    .dec_i  (w_timer_dec),
    .zero_o (w_timer_zero)
  );

  // Config FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      missing_q <= '0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (SET_CONFIG) begin
            state_q   <= ST_WAIT_ACK;
            mask_q    <= '0;
            missing_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (STOP) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (SET_CONFIG) begin
            // Restart: acks arriving with the new request are dropped
            mask_q    <= '0;
            missing_q <= '0;
          end else if (all_acked(w_next_mask)) begin
            // Checked before the timer so a last-cycle ack still completes
            state_q <= ST_IDLE;
            mask_q  <= w_next_mask;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (w_timer_zero) begin
            state_q   <= ST_IDLE;
            mask_q    <= w_next_mask;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            missing_q <= ~w_next_mask;
          end else begin
            mask_q <= w_next_mask;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A pending stop completes on the registered all-stopped flag; further
  // STOP pulses while pending are absorbed into the same request.
  assign w_stop_pending_d = (stop_pending_q && all_stopped_q) ? 1'b0
                                                              : (stop_pending_q || STOP);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      all_stopped_q  <= 1'b0;
      stop_pending_q <= 1'b0;
      stop_done_q    <= 1'b0;
    end else begin
      all_stopped_q  <= &w_stopped_vec;
      stop_pending_q <= w_stop_pending_d;
      stop_done_q    <= stop_pending_q && all_stopped_q;
    end
  end

  assign BUSY             = busy_q;
  assign CONFIG_DONE      = done_q;
  assign CONFIG_TIMEOUT   = timeout_q;
  assign MISSING_ACK_MASK = missing_q;
  assign STOP_DONE        = stop_done_q;
  assign ALL_STOPPED      = all_stopped_q;

endmodule
`default_nettype wire
